axi_read_ot: RTL and testbench
==============================

AXI_READ_OT -- requirements
Module: axi_read_ot

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width and width of cmd_len.
REQ-002 Parameter DATA_W, default 128, data width; legal values 32/64/128/256/512.
REQ-003 Parameter ID_W, default 4, AXI ID width.
REQ-004 Parameter LEN_W, default 8, arlen width.
REQ-005 Parameter BURST_MAX, default 256, max beats per burst; legal values 16 or 256.
REQ-006 Parameter MAX_OT, default 4, max outstanding AR bursts; range 1..16.
REQ-007 Parameter ID, default 0, constant driven on m_axi_arid.
REQ-008 sys_clk  in  1  sole clock; one clock; all logic rising-edge.
REQ-009 sys_rst_n  in  1  reset, asynchronous, active-low.
REQ-010 cmd_valid / cmd_ready  in / out  1 / 1  command handshake.
REQ-011 cmd_addr  in  ADDR_W  start byte address.
REQ-012 cmd_len  in  ADDR_W  transfer length in beats.
REQ-013 cmd_done  out  1  one-cycle pulse at command completion.
REQ-014 cmd_err  out  1  sticky error flag for the last command.
REQ-015 axis_valid, axis_ready, axis_last  out, in, out  1  stream handshake; axis_last marks the command's final beat.
REQ-016 axis_data  out  DATA_W  read data.
REQ-017 m_axi_ar*: arid ID_W, araddr ADDR_W, arlen LEN_W, arsize 3, arburst 2, arlock 1, arcache 4, arprot 3, arqos 4, arvalid out, arready in.
REQ-018 m_axi_r*: rid ID_W, rdata DATA_W, rresp 2, rlast 1, rvalid in; rready out.

Function
REQ-019 FSM states IDLE, CALC, ADDR, DRAIN; cmd_ready = 1 only in IDLE.
REQ-020 On cmd accept: addr aligned down to beat (low log2(DATA_W/8) bits zeroed), remaining = cmd_len, beat counter cleared, cmd_err cleared; go to CALC.
REQ-021 cmd_len = 0: no AR issued; cmd_done pulses 2 cycles after accept; return to IDLE.
REQ-022 CALC (1 cycle): burst = min(remaining, BURST_MAX − (beat_addr mod BURST_MAX), 4KB_beats − (beat_addr mod 4KB_beats)); no burst crosses a 4 KB boundary.
REQ-023 ADDR: arvalid asserted only when outstanding < MAX_OT; araddr/arlen = burst−1 held stable while arvalid & !arready.
REQ-024 On AR handshake: addr += burst×bytes, remaining −= burst; remaining ≠ 0 -> CALC, else DRAIN.
REQ-025 Outstanding counter: +1 on AR handshake, −1 on R handshake with rlast; both same cycle -> unchanged; never exceeds MAX_OT.
REQ-026 Data path combinational: rready = axis_ready, axis_valid = rvalid, axis_data = rdata.
REQ-027 axis_last = 1 when beat counter == cmd_len−1, independent of rlast.
REQ-028 rresp ≠ OKAY on any accepted beat sets cmd_err; held until next cmd accept.
REQ-029 cmd_done pulses 1 cycle after the axis_last handshake; FSM -> IDLE same edge.
REQ-030 arsize = log2(DATA_W/8); arburst = INCR; arcache = 4'b0011; arlock, arprot, arqos = 0.

Reset
REQ-031 sys_rst_n low: FSM IDLE, arvalid 0, araddr 0, arlen 0, cmd_done 0, cmd_err 0, counters 0, cmd_ready 1 after release.
REQ-032 Reset mid-operation abandons in-flight bursts; no recovery of outstanding R data is required.

Structure
REQ-033 Package axi_rd_pkg holds: arsize function, burst/cache/lock/prot constants, CLOG2 function, FSM state encoding.
REQ-034 Sub-module axi_rd_burst_calc (registered CALC-stage min computation) is natural; remainder flat.

Verification (DATA_W=128, 4 KB = 256 beats)
REQ-035 addr 0x0FF0, len 4 -> AR araddr 0x0FF0 arlen 0, then 0x1000 arlen 2; axis_last on beat 4; cmd_done once.
REQ-036 addr 0x0, len 600 -> arlen 255, 255, 87 at 0x0, 0x1000, 0x2000.
REQ-037 MAX_OT=2, slave withholds R, len 1024 -> exactly 2 ARs; 3rd AR issued only after first rlast handshake.
REQ-038 len 8, rresp = 2'b10 on beat 3 -> all 8 beats delivered, cmd_err = 1 at cmd_done; next cmd accept clears it.
REQ-039 len 0 -> no arvalid, cmd_done pulse; sys_rst_n low during burst -> arvalid 0 immediately, FSM IDLE, cmd_ready 1 after release.
REQ-040 axis_ready toggled randomly -> data order preserved, no beat lost or duplicated.

Source files
------------

// File: rtl/axi_rd_pkg.sv
// Shared types, AXI attribute constants and elaboration helpers for the
// outstanding-limited AXI read master.
package axi_rd_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CALC  = 2'd1,
      ADDR  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   localparam logic [1:0] BURST_INCR    = 2'b01;
   localparam logic [3:0] CACHE_DEFAULT = 4'b0011;
   localparam logic       LOCK_NORMAL   = 1'b0;
   localparam logic [2:0] PROT_DEFAULT  = 3'b000;
   localparam logic [3:0] QOS_DEFAULT   = 4'b0000;
   localparam int         PAGE_BYTES    = 4096;

   // Ceiling log2; clog2(1) is 0 so single-entry widths stay sane.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >> 1;
      end
      return r;
   endfunction

   function automatic logic [2:0] ar_size(input int data_w);
      return 3'(clog2(data_w / 8));
   endfunction

endpackage

// File: rtl/axi_rd_burst_calc.sv
// Registered burst sizing: the largest burst that fits the remaining length,
// the BURST_MAX alignment window and the current 4 KB page.
module axi_rd_burst_calc
   import axi_rd_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int BURST_MAX = 256
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [ADDR_W-1:0] addr,
   input  logic [ADDR_W-1:0] remaining,
   output logic [ADDR_W-1:0] burst
);

   localparam int SHIFT      = clog2(DATA_W / 8);
   localparam int PAGE_BEATS = PAGE_BYTES / (DATA_W / 8);

   logic [ADDR_W-1:0] beat_addr;
   logic [ADDR_W-1:0] to_max;
   logic [ADDR_W-1:0] to_page;
   logic [ADDR_W-1:0] limit;

   // Both windows are powers of two, so the modulo is a simple mask.
   always_comb begin
      beat_addr = addr >> SHIFT;
      to_max    = ADDR_W'(BURST_MAX) - (beat_addr & ADDR_W'(BURST_MAX - 1));
      to_page   = ADDR_W'(PAGE_BEATS) - (beat_addr & ADDR_W'(PAGE_BEATS - 1));
      limit     = (to_max < to_page) ? to_max : to_page;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         burst <= '0;
      end else if (load) begin
         burst <= (remaining < limit) ? remaining : limit;
      end
   end

endmodule

// File: rtl/axi_read_ot.sv
// AXI4 read master: splits a beat-count command into 4 KB-safe INCR bursts,
// keeps at most MAX_OT bursts in flight and streams read data out in order.
module axi_read_ot
   import axi_rd_pkg::*;
#(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 128,
   parameter int ID_W      = 4,
   parameter int LEN_W     = 8,
   parameter int BURST_MAX = 256,
   parameter int MAX_OT    = 4,
   parameter int ID        = 0
) (
   input  logic              sys_clk,
   input  logic              sys_rst_n,

   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [ADDR_W-1:0] cmd_addr,
   input  logic [ADDR_W-1:0] cmd_len,
   output logic              cmd_done,
   output logic              cmd_err,

   output logic              axis_valid,
   input  logic              axis_ready,
   output logic              axis_last,
   output logic [DATA_W-1:0] axis_data,

   output logic [ID_W-1:0]   m_axi_arid,
   output logic [ADDR_W-1:0] m_axi_araddr,
   output logic [LEN_W-1:0]  m_axi_arlen,
   output logic [2:0]        m_axi_arsize,
   output logic [1:0]        m_axi_arburst,
   output logic              m_axi_arlock,
   output logic [3:0]        m_axi_arcache,
   output logic [2:0]        m_axi_arprot,
   output logic [3:0]        m_axi_arqos,
   output logic              m_axi_arvalid,
   input  logic              m_axi_arready,

   input  logic [ID_W-1:0]   m_axi_rid,
   input  logic [DATA_W-1:0] m_axi_rdata,
   input  logic [1:0]        m_axi_rresp,
   input  logic              m_axi_rlast,
   input  logic              m_axi_rvalid,
   output logic              m_axi_rready
);

   localparam int                BYTES     = DATA_W / 8;
   localparam int                SHIFT     = clog2(BYTES);
   localparam int                OT_W      = clog2(MAX_OT + 1);
   localparam logic [ADDR_W-1:0] BEAT_MASK = ADDR_W'(BYTES - 1);

   state_t            state;
   logic [ADDR_W-1:0] addr_q;
   logic [ADDR_W-1:0] remaining;
   logic [ADDR_W-1:0] len_q;
   logic [ADDR_W-1:0] beat_cnt;
   logic [ADDR_W-1:0] burst;
   logic [OT_W-1:0]   ot_cnt;
   logic              accept;
   logic              ar_hs;
   logic              r_hs;
   logic              last_hs;
   logic              ot_room;
   logic              unused_ok;

   assign cmd_ready = (state == IDLE);
   assign accept    = cmd_valid && cmd_ready;
   assign ar_hs     = m_axi_arvalid && m_axi_arready;
   assign r_hs      = m_axi_rvalid && axis_ready;
   assign last_hs   = r_hs && axis_last;
   assign ot_room   = (ot_cnt < OT_W'(MAX_OT));

   // Data is passed through untouched; only the command framing is added.
   assign m_axi_rready = axis_ready;
   assign axis_valid   = m_axi_rvalid;
   assign axis_data    = m_axi_rdata;
   assign axis_last    = (beat_cnt == len_q - ADDR_W'(1));

   assign m_axi_arid    = ID_W'(ID);
   assign m_axi_arsize  = ar_size(DATA_W);
   assign m_axi_arburst = BURST_INCR;
   assign m_axi_arlock  = LOCK_NORMAL;
   assign m_axi_arcache = CACHE_DEFAULT;
   assign m_axi_arprot  = PROT_DEFAULT;
   assign m_axi_arqos   = QOS_DEFAULT;

   assign unused_ok = ^m_axi_rid;

   axi_rd_burst_calc #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST_MAX (BURST_MAX)
   ) u_burst_calc (
      .clk       (sys_clk),
      .rst_n     (sys_rst_n),
      .load      (state == CALC),
      .addr      (addr_q),
      .remaining (remaining),
      .burst     (burst)
   );

   // arvalid is only raised once there is room, so the in-flight count can
   // never overshoot while the request waits for arready.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state         <= IDLE;
         addr_q        <= '0;
         remaining     <= '0;
         len_q         <= '0;
         m_axi_arvalid <= 1'b0;
         m_axi_araddr  <= '0;
         m_axi_arlen   <= '0;
         cmd_done      <= 1'b0;
      end else begin
         cmd_done <= 1'b0;
         case (state)
            IDLE: begin
               if (cmd_valid) begin
                  addr_q    <= cmd_addr & ~BEAT_MASK;
                  remaining <= cmd_len;
                  len_q     <= cmd_len;
                  state     <= CALC;
               end
            end
            CALC: begin
               state <= (remaining == '0) ? DRAIN : ADDR;
            end
            ADDR: begin
               if (!m_axi_arvalid) begin
                  if (ot_room) begin
                     m_axi_arvalid <= 1'b1;
                     m_axi_araddr  <= addr_q;
                     m_axi_arlen   <= LEN_W'(burst - ADDR_W'(1));
                  end
               end else if (m_axi_arready) begin
                  m_axi_arvalid <= 1'b0;
                  addr_q        <= addr_q + (burst << SHIFT);
                  remaining     <= remaining - burst;
                  state         <= (remaining == burst) ? DRAIN : CALC;
               end
            end
            DRAIN: begin
               if ((len_q == '0) || last_hs) begin
                  cmd_done <= 1'b1;
                  state    <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         beat_cnt <= '0;
      end else if (accept) begin
         beat_cnt <= '0;
      end else if (r_hs) begin
         beat_cnt <= beat_cnt + ADDR_W'(1);
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cmd_err <= 1'b0;
      end else if (accept) begin
         cmd_err <= 1'b0;
      end else if (r_hs && (m_axi_rresp != 2'b00)) begin
         cmd_err <= 1'b1;
      end
   end

   // A burst retires on its rlast beat; issue and retire together cancel out.
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         ot_cnt <= '0;
      end else begin
         case ({ar_hs, r_hs && m_axi_rlast})
            2'b10:   ot_cnt <= ot_cnt + OT_W'(1);
            2'b01:   if (ot_cnt != '0) ot_cnt <= ot_cnt - OT_W'(1);
            default: ot_cnt <= ot_cnt;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_read_ot.sv
// Directed bench for axi_read_ot: AXI slave model, AR and data scoreboards,
// outstanding-limit, error flag, zero-length and mid-burst reset scenarios.
module tb_axi_read_ot;

   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 128;
   localparam int ID_W      = 4;
   localparam int LEN_W     = 8;
   localparam int BURST_MAX = 256;
   localparam int MAX_OT    = 2;
   localparam int ID        = 5;

   logic              sys_clk = 1'b0;
   logic              sys_rst_n = 1'b0;
   logic              cmd_valid, cmd_ready, cmd_done, cmd_err;
   logic [ADDR_W-1:0] cmd_addr, cmd_len;
   logic              axis_valid, axis_ready, axis_last;
   logic [DATA_W-1:0] axis_data;
   logic [ID_W-1:0]   m_axi_arid, m_axi_rid;
   logic [ADDR_W-1:0] m_axi_araddr;
   logic [LEN_W-1:0]  m_axi_arlen;
   logic [2:0]        m_axi_arsize, m_axi_arprot;
   logic [1:0]        m_axi_arburst, m_axi_rresp;
   logic              m_axi_arlock, m_axi_arvalid, m_axi_arready;
   logic [3:0]        m_axi_arcache, m_axi_arqos;
   logic [DATA_W-1:0] m_axi_rdata;
   logic              m_axi_rlast, m_axi_rvalid, m_axi_rready;

   int checks = 0;
   int passes = 0;
   int fails  = 0;

   logic [31:0]       ar_exp_addr[$];
   logic [7:0]        ar_exp_len[$];
   logic [DATA_W-1:0] beat_exp_data[$];
   logic              beat_exp_last[$];

   logic r_hold       = 1'b0;
   logic ready_random = 1'b0;
   logic ar_stall     = 1'b0;
   int   err_beat     = -1;

   int   done_count     = 0;
   int   ar_count       = 0;
   int   arvalid_cycles = 0;

   axi_read_ot #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W),
      .BURST_MAX(BURST_MAX), .MAX_OT(MAX_OT), .ID(ID)
   ) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
      .cmd_len(cmd_len), .cmd_done(cmd_done), .cmd_err(cmd_err),
      .axis_valid(axis_valid), .axis_ready(axis_ready), .axis_last(axis_last),
      .axis_data(axis_data),
      .m_axi_arid(m_axi_arid), .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen),
      .m_axi_arsize(m_axi_arsize), .m_axi_arburst(m_axi_arburst),
      .m_axi_arlock(m_axi_arlock), .m_axi_arcache(m_axi_arcache),
      .m_axi_arprot(m_axi_arprot), .m_axi_arqos(m_axi_arqos),
      .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
      .m_axi_rid(m_axi_rid), .m_axi_rdata(m_axi_rdata), .m_axi_rresp(m_axi_rresp),
      .m_axi_rlast(m_axi_rlast), .m_axi_rvalid(m_axi_rvalid), .m_axi_rready(m_axi_rready)
   );

   always #5 sys_clk = ~sys_clk;

   function automatic logic [DATA_W-1:0] data_of(input logic [31:0] a);
      return {a ^ 32'h1111_0000, ~a, a + 32'h55, a};
   endfunction

   task automatic checkOutput(input string tag, input logic [127:0] observed,
                              input logic [127:0] expected);
      checks++;
      assert (observed === expected) passes++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   task automatic expectAr(input logic [31:0] a, input logic [7:0] l);
      ar_exp_addr.push_back(a);
      ar_exp_len.push_back(l);
   endtask

   task automatic expectBeats(input logic [31:0] a, input int n);
      for (int i = 0; i < n; i++) begin
         beat_exp_data.push_back(data_of((a & ~32'hF) + 32'(i * 16)));
         beat_exp_last.push_back(i == n - 1);
      end
   endtask

   // Returns #1 after the accepting clock edge.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] n);
      int t;
      @(posedge sys_clk); #1;
      cmd_valid = 1'b1;
      cmd_addr  = a;
      cmd_len   = n;
      t = 0;
      forever begin
         @(negedge sys_clk);
         if (cmd_ready) break;
         t++;
         if (t > 200) begin
            checkOutput("cmd_accept_timeout", cmd_ready, 1);
            break;
         end
      end
      @(posedge sys_clk); #1;
      cmd_valid = 1'b0;
   endtask

   task automatic waitDone(input string tag, input int target, input int budget);
      int t;
      t = 0;
      while (done_count < target && t < budget) begin
         @(negedge sys_clk);
         t++;
      end
      checkOutput(tag, done_count, target);
   endtask

   initial begin
      axis_ready = 1'b0;
      forever begin
         @(posedge sys_clk); #1;
         axis_ready = ready_random ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   // Slave model and monitors: sample at negedge, respond just after posedge.
   initial begin : slave
      logic        ar_fire, r_fire, r_last_fire, accept;
      logic [31:0] a;
      logic [7:0]  l;
      logic        ar_hold_valid;
      logic [31:0] hold_addr;
      logic [7:0]  hold_len;
      logic [31:0] bq_addr[$];
      int          bq_len[$];
      int          beat_idx, served, slave_ot;
      ar_hold_valid = 1'b0; hold_addr = '0; hold_len = '0;
      beat_idx = 0; served = 0; slave_ot = 0;
      m_axi_arready = 1'b0; m_axi_rvalid = 1'b0; m_axi_rlast = 1'b0;
      m_axi_rdata = '0; m_axi_rresp = 2'b00; m_axi_rid = ID_W'(ID);
      forever begin
         @(negedge sys_clk);
         ar_fire     = m_axi_arvalid && m_axi_arready;
         r_fire      = m_axi_rvalid && m_axi_rready;
         r_last_fire = r_fire && m_axi_rlast;
         accept      = cmd_valid && cmd_ready;
         a = m_axi_araddr;
         l = m_axi_arlen;
         if (sys_rst_n) begin
            if (m_axi_arvalid) arvalid_cycles++;
            if (ar_hold_valid) begin
               checkOutput("ar_held", m_axi_arvalid, 1);
               checkOutput("ar_stable_addr", m_axi_araddr, hold_addr);
               checkOutput("ar_stable_len", m_axi_arlen, hold_len);
            end
            ar_hold_valid = m_axi_arvalid && !m_axi_arready;
            hold_addr = m_axi_araddr;
            hold_len  = m_axi_arlen;
            if (ar_fire) begin
               checkOutput("ar_ot_limit", slave_ot < MAX_OT, 1);
               if (ar_exp_addr.size() == 0) begin
                  checkOutput("ar_unexpected", ar_exp_addr.size(), 1);
               end else begin
                  checkOutput("ar_addr", a, ar_exp_addr.pop_front());
                  checkOutput("ar_len", l, ar_exp_len.pop_front());
               end
            end
            if (axis_valid && axis_ready) begin
               if (beat_exp_data.size() == 0) begin
                  checkOutput("beat_unexpected", beat_exp_data.size(), 1);
               end else begin
                  checkOutput("beat_data", axis_data, beat_exp_data.pop_front());
                  checkOutput("beat_last", axis_last, beat_exp_last.pop_front());
               end
            end
            if (cmd_done) done_count++;
         end
         @(posedge sys_clk); #1;
         if (!sys_rst_n) begin
            bq_addr.delete();
            bq_len.delete();
            beat_idx = 0; served = 0; slave_ot = 0;
            ar_hold_valid = 1'b0;
            m_axi_rvalid = 1'b0;
            m_axi_rlast  = 1'b0;
         end else begin
            if (accept) served = 0;
            if (r_fire && bq_len.size() > 0) begin
               served++;
               if (beat_idx == bq_len[0]) begin
                  void'(bq_addr.pop_front());
                  void'(bq_len.pop_front());
                  beat_idx = 0;
               end else begin
                  beat_idx++;
               end
            end
            if (r_last_fire && slave_ot > 0) slave_ot--;
            if (ar_fire) begin
               bq_addr.push_back(a);
               bq_len.push_back(int'(l));
               slave_ot++;
               ar_count++;
            end
            m_axi_arready = ar_stall ? 1'b0 : ($urandom_range(0, 3) != 0);
            if (!r_hold && bq_addr.size() > 0) begin
               m_axi_rvalid = 1'b1;
               m_axi_rdata  = data_of(bq_addr[0] + 32'(beat_idx * 16));
               m_axi_rlast  = (beat_idx == bq_len[0]);
               m_axi_rresp  = (served == err_beat) ? 2'b10 : 2'b00;
            end else begin
               m_axi_rvalid = 1'b0;
               m_axi_rlast  = 1'b0;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog expired checks=%0d passes=%0d", checks, passes);
      $fatal(1, "[TB] watchdog");
   end

   initial begin : main
      int base;
      int t;
      cmd_valid = 1'b0;
      cmd_addr  = '0;
      cmd_len   = '0;

      repeat (3) @(posedge sys_clk);
      #1 sys_rst_n = 1'b1;
      @(negedge sys_clk);
      checkOutput("rst_cmd_ready", cmd_ready, 1);
      checkOutput("rst_arvalid", m_axi_arvalid, 0);
      checkOutput("rst_araddr", m_axi_araddr, 0);
      checkOutput("rst_arlen", m_axi_arlen, 0);
      checkOutput("rst_cmd_done", cmd_done, 0);
      checkOutput("rst_cmd_err", cmd_err, 0);
      checkOutput("const_arsize", m_axi_arsize, 3'd4);
      checkOutput("const_arburst", m_axi_arburst, 2'b01);
      checkOutput("const_arcache", m_axi_arcache, 4'b0011);
      checkOutput("const_lock_prot_qos", {m_axi_arlock, m_axi_arprot, m_axi_arqos}, 0);
      checkOutput("const_arid", m_axi_arid, 4'd5);

      $display("[TB] page crossing split");
      expectAr(32'h0FF0, 8'd0);
      expectAr(32'h1000, 8'd2);
      expectBeats(32'h0FF0, 4);
      applyStimulus(32'h0FF0, 4);
      waitDone("a_done", 1, 2000);
      repeat (5) @(negedge sys_clk);
      checkOutput("a_done_once", done_count, 1);
      checkOutput("a_err", cmd_err, 0);
      checkOutput("a_ar_all", ar_exp_addr.size(), 0);
      checkOutput("a_beats_all", beat_exp_data.size(), 0);

      $display("[TB] long command with random backpressure");
      ready_random = 1'b1;
      expectAr(32'h0000, 8'd255);
      expectAr(32'h1000, 8'd255);
      expectAr(32'h2000, 8'd87);
      expectBeats(32'h0, 600);
      applyStimulus(32'h0, 600);
      waitDone("b_done", 2, 8000);
      checkOutput("b_ar_all", ar_exp_addr.size(), 0);
      checkOutput("b_beats_all", beat_exp_data.size(), 0);
      ready_random = 1'b0;

      $display("[TB] outstanding limit with withheld data");
      r_hold = 1'b1;
      expectAr(32'h4000, 8'd255);
      expectAr(32'h5000, 8'd255);
      expectAr(32'h6000, 8'd255);
      expectAr(32'h7000, 8'd255);
      expectBeats(32'h4000, 1024);
      base = ar_count;
      applyStimulus(32'h4000, 1024);
      repeat (40) @(negedge sys_clk);
      checkOutput("c_two_ar", ar_count - base, 2);
      checkOutput("c_arvalid_blocked", m_axi_arvalid, 0);
      checkOutput("c_no_data", beat_exp_data.size(), 1024);
      r_hold = 1'b0;
      waitDone("c_done", 3, 8000);
      checkOutput("c_four_ar", ar_count - base, 4);
      checkOutput("c_beats_all", beat_exp_data.size(), 0);

      $display("[TB] error response on third beat");
      err_beat = 2;
      expectAr(32'h0200, 8'd7);
      expectBeats(32'h0200, 8);
      applyStimulus(32'h0200, 8);
      waitDone("d_done", 4, 2000);
      checkOutput("d_err_set", cmd_err, 1);
      checkOutput("d_beats_all", beat_exp_data.size(), 0);
      err_beat = -1;

      $display("[TB] zero length command");
      base = arvalid_cycles;
      t = ar_count;
      applyStimulus(32'h0300, 0);
      checkOutput("e_err_cleared", cmd_err, 0);
      checkOutput("e_done_early", cmd_done, 0);
      @(posedge sys_clk); #1;
      checkOutput("e_done_wait", cmd_done, 0);
      @(posedge sys_clk); #1;
      checkOutput("e_done_pulse", cmd_done, 1);
      @(posedge sys_clk); #1;
      checkOutput("e_done_single", cmd_done, 0);
      repeat (3) @(negedge sys_clk);
      checkOutput("e_no_arvalid", arvalid_cycles - base, 0);
      checkOutput("e_no_ar", ar_count - t, 0);
      checkOutput("e_ready", cmd_ready, 1);

      $display("[TB] reset during a pending request");
      ar_stall = 1'b1;
      r_hold = 1'b1;
      expectAr(32'h0800, 8'd63);
      applyStimulus(32'h0800, 64);
      t = 0;
      while (!m_axi_arvalid && t < 50) begin
         @(negedge sys_clk);
         t++;
      end
      checkOutput("f_arvalid_up", m_axi_arvalid, 1);
      sys_rst_n = 1'b0;
      #1;
      checkOutput("f_arvalid_reset", m_axi_arvalid, 0);
      checkOutput("f_araddr_reset", m_axi_araddr, 0);
      repeat (3) @(posedge sys_clk);
      ar_exp_addr.delete();
      ar_exp_len.delete();
      beat_exp_data.delete();
      beat_exp_last.delete();
      ar_stall = 1'b0;
      r_hold = 1'b0;
      #1 sys_rst_n = 1'b1;
      @(negedge sys_clk);
      checkOutput("f_ready_after", cmd_ready, 1);
      checkOutput("f_arvalid_after", m_axi_arvalid, 0);
      checkOutput("f_err_after", cmd_err, 0);

      $display("[TB] recovery with unaligned address");
      expectAr(32'h0040, 8'd2);
      expectBeats(32'h004C, 3);
      applyStimulus(32'h004C, 3);
      waitDone("g_done", 6, 2000);
      checkOutput("g_ar_all", ar_exp_addr.size(), 0);
      checkOutput("g_beats_all", beat_exp_data.size(), 0);
      checkOutput("g_err", cmd_err, 0);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
